// File: rtl/param_updown_counter.sv
// Parametrised up/down counter with programmable modulus, wrap/saturate mode,
// synchronous clear and clamped load, terminal count and sticky wrap flag.
module param_updown_counter #(
    parameter int unsigned      WIDTH    = 4,
    parameter longint unsigned  MOD_MAX  = (64'd1 << WIDTH) - 64'd1,
    parameter bit               SATURATE = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             up_dn,
    input  logic             clear,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             wrap_flag
);

    localparam logic [WIDTH-1:0] MAXV = WIDTH'(MOD_MAX);

    logic [WIDTH-1:0] count_nxt;
    logic             flag_nxt;
    logic             at_max;
    logic             at_zero;

    assign at_max  = (count == MAXV);
    assign at_zero = (count == '0);
    assign tc      = en & ~clear & ~load &
                     ((up_dn & at_max) | (~up_dn & at_zero));

    always_comb begin
        count_nxt = count;
        flag_nxt  = wrap_flag;
        if (clear) begin
            count_nxt = '0;
            flag_nxt  = 1'b0;
        end else if (load) begin
            count_nxt = (load_val > MAXV) ? MAXV : load_val;
        end else if (en) begin
            if (tc) begin
                // range end: either wrap to the opposite end or hold
                flag_nxt = 1'b1;
                if (!SATURATE)
                    count_nxt = up_dn ? '0 : MAXV;
            end else if (up_dn) begin
                count_nxt = count + WIDTH'(1);
            end else begin
                count_nxt = count - WIDTH'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count     <= '0;
            wrap_flag <= 1'b0;
        end else begin
            count     <= count_nxt;
            wrap_flag <= flag_nxt;
        end
    end

endmodule

// File: tb/tb_param_updown_counter.sv
// Bench for param_updown_counter: three configurations driven in lockstep,
// expected results queued per cycle and compared after each edge.
module tb_param_updown_counter;

    logic       clk = 1'b0;
    logic       rst;
    logic       en, up_dn, clear, load;
    logic [3:0] load_val;
    logic [3:0] c0, c1, c2;
    logic       tc0, tc1, tc2;
    logic       w0, w1, w2;

    always #5 clk = ~clk;

    param_updown_counter #(.WIDTH(4)) u_wrap16 (
        .clk(clk), .rst(rst), .en(en), .up_dn(up_dn), .clear(clear),
        .load(load), .load_val(load_val), .count(c0), .tc(tc0), .wrap_flag(w0));

    param_updown_counter #(.WIDTH(4), .MOD_MAX(9), .SATURATE(1'b0)) u_mod9 (
        .clk(clk), .rst(rst), .en(en), .up_dn(up_dn), .clear(clear),
        .load(load), .load_val(load_val), .count(c1), .tc(tc1), .wrap_flag(w1));

    param_updown_counter #(.WIDTH(4), .MOD_MAX(9), .SATURATE(1'b1)) u_sat9 (
        .clk(clk), .rst(rst), .en(en), .up_dn(up_dn), .clear(clear),
        .load(load), .load_val(load_val), .count(c2), .tc(tc2), .wrap_flag(w2));

    typedef struct packed {
        logic [3:0] c0, c1, c2;
        logic       w0, w1, w2;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    int   mmax[3] = '{15, 9, 9};
    bit   msat[3] = '{1'b0, 1'b0, 1'b1};
    int   mc[3];
    bit   mf[3];
    logic [3:0] ripple;
    int   seq3[7] = '{7, 8, 9, 9, 9, 8, 7};

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic dut_tc(input int i);
        case (i)
            0: return tc0;
            1: return tc1;
            default: return tc2;
        endcase
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 3; i++) begin
            mc[i] = 0;
            mf[i] = 1'b0;
        end
        q.delete();
    endtask

    task automatic cycle(input bit e, input bit u, input bit c,
                         input bit l, input logic [3:0] v);
        exp_t x;
        en = e; up_dn = u; clear = c; load = l; load_val = v;
        #1;
        for (int i = 0; i < 3; i++) begin
            bit t;
            t = e && !c && !l && ((u && mc[i] == mmax[i]) || (!u && mc[i] == 0));
            chk($sformatf("tc%0d", i), 32'(dut_tc(i)), 32'(t));
            if (c) begin
                mc[i] = 0;
                mf[i] = 1'b0;
            end else if (l) begin
                mc[i] = (int'(v) > mmax[i]) ? mmax[i] : int'(v);
            end else if (e) begin
                if (t) begin
                    mf[i] = 1'b1;
                    if (!msat[i]) mc[i] = u ? 0 : mmax[i];
                end else begin
                    mc[i] = u ? mc[i] + 1 : mc[i] - 1;
                end
            end
        end
        x.c0 = 4'(mc[0]); x.c1 = 4'(mc[1]); x.c2 = 4'(mc[2]);
        x.w0 = mf[0];     x.w1 = mf[1];     x.w2 = mf[2];
        q.push_back(x);
        @(posedge clk);
        #1;
        if (q.size() == 0) begin
            chk("queue_empty", 32'd0, 32'd1);
        end else begin
            x = q.pop_front();
            chk("count0", 32'(c0), 32'(x.c0));
            chk("count1", 32'(c1), 32'(x.c1));
            chk("count2", 32'(c2), 32'(x.c2));
            chk("flag0",  32'(w0), 32'(x.w0));
            chk("flag1",  32'(w1), 32'(x.w1));
            chk("flag2",  32'(w2), 32'(x.w2));
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_c0"}, 32'(c0), 32'd0);
        chk({tag, "_c1"}, 32'(c1), 32'd0);
        chk({tag, "_c2"}, 32'(c2), 32'd0);
        chk({tag, "_w0"}, 32'(w0), 32'd0);
        chk({tag, "_w1"}, 32'(w1), 32'd0);
        chk({tag, "_w2"}, 32'(w2), 32'd0);
    endtask

    task automatic pulse_reset();
        #3 rst = 1'b1;
        #1 chk_all_zero("async_rst");
        #1 rst = 1'b0;
        model_reset();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1;
        en = 1'b0; up_dn = 1'b0; clear = 1'b0; load = 1'b0; load_val = '0;
        model_reset();
        #12;
        chk_all_zero("reset");
        rst = 1'b0;
        @(posedge clk);
        #1;

        // up count, compared against an independent 4-bit ripple counter
        ripple = 4'd0;
        for (int k = 0; k < 20; k++) begin
            cycle(1'b1, 1'b1, 1'b0, 1'b0, 4'd0);
            ripple = ripple + 4'd1;
            chk("ripple", 32'(c0), 32'(ripple));
            if (k == 15) chk("wrap_after_15", 32'(w0), 32'd1);
        end

        // priority: clear beats load and en
        cycle(1'b1, 1'b1, 1'b0, 1'b0, 4'd0);
        cycle(1'b1, 1'b1, 1'b0, 1'b0, 4'd0);
        chk("pre_prio_c0", 32'(c0), 32'd6);
        cycle(1'b1, 1'b1, 1'b1, 1'b1, 4'd3);
        chk("prio_c0", 32'(c0), 32'd0);
        chk("prio_w0", 32'(w0), 32'd0);
        cycle(1'b0, 1'b1, 1'b0, 1'b1, 4'd15);
        chk("at15_tc", 32'(tc0), 32'd0);
        cycle(1'b1, 1'b1, 1'b1, 1'b0, 4'd0);
        chk("clr_wins_w0", 32'(w0), 32'd0);
        chk("clr_wins_c0", 32'(c0), 32'd0);

        // down count from reset, mod 9
        pulse_reset();
        for (int k = 0; k < 12; k++)
            cycle(1'b1, 1'b0, 1'b0, 1'b0, 4'd0);
        chk("down_c1", 32'(c1), 32'd8);
        chk("down_w1", 32'(w1), 32'd1);

        // load clamp and load beating en
        cycle(1'b0, 1'b1, 1'b0, 1'b1, 4'd13);
        chk("clamp_c1", 32'(c1), 32'd9);
        cycle(1'b1, 1'b1, 1'b0, 1'b1, 4'd4);
        chk("load_en_c1", 32'(c1), 32'd4);

        // saturating run: load 7, up to 9 and hold, then down
        pulse_reset();
        cycle(1'b0, 1'b1, 1'b0, 1'b1, 4'd7);
        chk("sat_seq0", 32'(c2), 32'(seq3[0]));
        for (int k = 1; k < 7; k++) begin
            cycle(1'b1, (k < 5), 1'b0, 1'b0, 4'd0);
            chk($sformatf("sat_seq%0d", k), 32'(c2), 32'(seq3[k]));
            if (k == 3) chk("sat_w2", 32'(w2), 32'd1);
        end

        // direction change with no dead cycle
        cycle(1'b0, 1'b1, 1'b0, 1'b1, 4'd5);
        cycle(1'b1, 1'b1, 1'b0, 1'b0, 4'd0);
        cycle(1'b1, 1'b0, 1'b0, 1'b0, 4'd0);
        chk("dir_c0", 32'(c0), 32'd5);

        // async reset mid-count with the flag set
        cycle(1'b0, 1'b1, 1'b0, 1'b1, 4'd15);
        cycle(1'b1, 1'b1, 1'b0, 1'b0, 4'd0);
        cycle(1'b0, 1'b1, 1'b0, 1'b1, 4'd11);
        chk("pre_rst_w0", 32'(w0), 32'd1);
        chk("pre_rst_c0", 32'(c0), 32'd11);
        pulse_reset();
        for (int k = 1; k <= 3; k++) begin
            cycle(1'b1, 1'b1, 1'b0, 1'b0, 4'd0);
            chk($sformatf("resume%0d", k), 32'(c0), 32'(k));
        end

        // pseudo-random mix through the scoreboard
        for (int k = 0; k < 200; k++)
            cycle(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 15) == 0), 1'($urandom_range(0, 7) == 0),
                  4'($urandom_range(0, 15)));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
